// File: rtl/rp8_io_master_if.sv
`default_nettype none
// ============================================================================
// Module      : rp8_io_master_if
// Description : Request/response and peripheral strobe bundle for rp8_io_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface rp8_io_master_if #(
    parameter int NRG = 3
);
    logic           req_vld;
    logic           req_rdy;
    logic           req_we;
    logic [5:0]     req_adr;
    logic [7:0]     req_wdt;
    logic           rsp_vld;
    logic           rsp_rdy;
    logic [7:0]     rsp_rdt;
    logic           rsp_err;
    logic [NRG-1:0] io_re;
    logic [NRG-1:0] io_we;
    logic [7:0]     io_dw;
    logic [7:0]     io_dr;

    modport master (
        input  req_vld, req_we, req_adr, req_wdt, rsp_rdy, io_dr,
        output req_rdy, rsp_vld, rsp_rdt, rsp_err, io_re, io_we, io_dw
    );

    modport slave (
        output req_vld, req_we, req_adr, req_wdt, rsp_rdy, io_dr,
        input  req_rdy, rsp_vld, rsp_rdt, rsp_err, io_re, io_we, io_dw
    );
endinterface
`default_nettype wire

// File: rtl/rp8_io_master.sv
`default_nettype none
// ============================================================================
// Module      : rp8_io_master
// Description : rp8 I/O bus initiator; one request -> one-hot io_re/io_we strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module rp8_io_master #(
    parameter int         NRG  = 3,
    parameter logic [5:0] ADR  = 6'h00,
    parameter int         WAIT = 0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    rp8_io_master_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STRB = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [3:0] c_wait_ld = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam logic [6:0] c_nrg     = 7'(NRG);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_we;
    logic [2:0]     r_off;
    logic [7:0]     r_wdt;
    logic [7:0]     r_rdt;
    logic           r_err;
    logic [3:0]     r_cnt;

    logic [6:0]     w_off;
    logic           w_hit;
    logic           w_acc;
    logic [NRG-1:0] w_onehot;

    // 7-bit subtraction: addresses below ADR become large and never match
    assign w_off = {1'b0, bus.req_adr} - {1'b0, ADR};
    assign w_hit = (w_off < c_nrg);
    assign w_acc = bus.req_vld && (r_state == S_IDLE);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NRG; i++) begin
            w_onehot[i] = (r_off == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = w_hit ? S_STRB : S_RESP;
                end
            end
            S_STRB: begin
                w_state_nxt = (WAIT > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we  <= 1'b0;
            r_off <= 3'd0;
            r_wdt <= 8'h00;
            r_rdt <= 8'h00;
            r_err <= 1'b0;
            r_cnt <= 4'd0;
        end else begin
            if (w_acc) begin
                r_we  <= bus.req_we;
                r_off <= w_off[2:0];
                r_wdt <= bus.req_wdt;
                r_rdt <= 8'h00;
                r_err <= ~w_hit;
            end
            // io_dr is only trusted during a read strobe
            if ((r_state == S_STRB) && !r_we) begin
                r_rdt <= bus.io_dr;
            end
            if (r_state == S_STRB) begin
                r_cnt <= c_wait_ld;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign bus.req_rdy = (r_state == S_IDLE);
    assign bus.rsp_vld = (r_state == S_RESP);
    assign bus.rsp_rdt = r_rdt;
    assign bus.rsp_err = r_err;
    assign bus.io_re   = ((r_state == S_STRB) && !r_we) ? w_onehot : '0;
    assign bus.io_we   = ((r_state == S_STRB) &&  r_we) ? w_onehot : '0;
    assign bus.io_dw   = ((r_state == S_STRB) &&  r_we) ? r_wdt    : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_rp8_io_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_rp8_io_master
// Description : Self-checking bench for rp8_io_master, three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rp8_io_master;

    localparam int NK = 3;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic seed = 1'b1;
    int   cyc  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NK-1:0]       req_vld = '0;
    logic [NK-1:0]       req_we  = '0;
    logic [NK-1:0]       rsp_rdy = '0;
    logic [NK-1:0][5:0]  req_adr = '0;
    logic [NK-1:0][7:0]  req_wdt = '0;
    logic [NK-1:0][7:0]  dr_w;
    wire  [NK-1:0]       rdy_w, vld_w, err_w;
    wire  [NK-1:0][7:0]  rdt_w, dw_w;
    wire  [NK-1:0][2:0]  re_w, we_w;

    // k=0: ADR 0x20 WAIT 0; k=1: ADR 0x20 WAIT 3; k=2: ADR 0x3E WAIT 0
    for (genvar g = 0; g < NK; g++) begin : g_dut
        localparam logic [5:0] A = (g == 2) ? 6'h3E : 6'h20;
        localparam int         W = (g == 1) ? 3 : 0;
        rp8_io_master_if #(.NRG(3)) bus ();
        rp8_io_master #(.NRG(3), .ADR(A), .WAIT(W)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.req_vld = req_vld[g];
        assign bus.req_we  = req_we[g];
        assign bus.req_adr = req_adr[g];
        assign bus.req_wdt = req_wdt[g];
        assign bus.rsp_rdy = rsp_rdy[g];
        assign bus.io_dr   = dr_w[g];
        assign rdy_w[g]    = bus.req_rdy;
        assign vld_w[g]    = bus.rsp_vld;
        assign err_w[g]    = bus.rsp_err;
        assign rdt_w[g]    = bus.rsp_rdt;
        assign dw_w[g]     = bus.io_dw;
        assign re_w[g]     = bus.io_re;
        assign we_w[g]     = bus.io_we;
    end

    // Peripheral register banks; io_dr is X whenever no read strobe is up
    logic [7:0] preg [NK][3];

    always_comb begin
        for (int k = 0; k < NK; k++) begin
            dr_w[k] = 8'hxx;
            for (int i = 0; i < 3; i++) begin
                if (re_w[k][i]) dr_w[k] = preg[k][i];
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (seed)            preg[k][i] <= 8'hA4 + 8'(k * 16 + i);
                else if (we_w[k][i]) preg[k][i] <= dw_w[k];
            end
        end
    end

    // Strobe monitor: records every strobe cycle and counts protocol violations
    int         n_strb   [NK] = '{default: 0};
    int         bad      [NK] = '{default: 0};
    int         last_cyc [NK] = '{default: 0};
    logic [2:0] last_re  [NK];
    logic [2:0] last_we  [NK];
    logic [7:0] last_dw  [NK];

    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if ((re_w[k] | we_w[k]) != 3'b000) begin
                n_strb[k]   = n_strb[k] + 1;
                last_cyc[k] = cyc;
                last_re[k]  = re_w[k];
                last_we[k]  = we_w[k];
                last_dw[k]  = dw_w[k];
            end
            if ($countones({re_w[k], we_w[k]}) > 1 || (we_w[k] == 3'b000 && dw_w[k] != 8'h00))
                bad[k] = bad[k] + 1;
        end
    end

    // Transaction-level reference model
    logic [7:0] ref_mem [NK][3];

    function automatic logic [5:0] base_of(input int k);
        return (k == 2) ? 6'h3E : 6'h20;
    endfunction

    function automatic int wait_of(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int k, input bit we, input logic [5:0] adr,
                       input logic [7:0] wdt, input int dly, input bit hold);
        int         off, n, s0, c_acc;
        bit         err;
        logic [7:0] exp_rdt;
        off     = int'(adr) - int'(base_of(k));
        err     = (off < 0) || (off >= 3);
        exp_rdt = 8'h00;
        if (!err && !we) exp_rdt = ref_mem[k][off];
        if (!err &&  we) ref_mem[k][off] = wdt;

        chk("idle_req_rdy", rdy_w[k], 1);
        s0         = n_strb[k];
        c_acc      = cyc;
        req_vld[k] = 1'b1;
        req_we[k]  = we;
        req_adr[k] = adr;
        req_wdt[k] = wdt;
        rsp_rdy[k] = (dly == 0);
        @(negedge clk);
        if (!hold) req_vld[k] = 1'b0;
        n = 1;
        while (!vld_w[k] && n < 40) begin
            chk("busy_req_rdy", rdy_w[k], 0);
            @(negedge clk);
            n++;
        end
        chk("latency", n, err ? 1 : 2 + wait_of(k));
        chk("rsp_req_rdy", rdy_w[k], 0);
        chk("rsp_rdt", rdt_w[k], exp_rdt);
        chk("rsp_err", err_w[k], err);
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            chk("hold_vld", vld_w[k], 1);
            chk("hold_rdt", rdt_w[k], exp_rdt);
            chk("hold_req_rdy", rdy_w[k], 0);
        end
        rsp_rdy[k] = 1'b1;
        @(negedge clk);
        rsp_rdy[k] = 1'b0;
        req_vld[k] = 1'b0;
        chk("post_vld", vld_w[k], 0);
        chk("post_req_rdy", rdy_w[k], 1);
        chk("strobe_count", n_strb[k] - s0, err ? 0 : 1);
        if (!err) begin
            chk("strobe_cycle", last_cyc[k], c_acc + 1);
            chk("strobe_re", last_re[k], we ? 3'b000 : 3'(1 << off));
            chk("strobe_we", last_we[k], we ? 3'(1 << off) : 3'b000);
            chk("strobe_dw", last_dw[k], we ? wdt : 8'h00);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         s0, k, dly;
        logic [5:0] a;
        for (int kk = 0; kk < NK; kk++)
            for (int i = 0; i < 3; i++) ref_mem[kk][i] = 8'hA4 + 8'(kk * 16 + i);

        repeat (3) @(negedge clk);
        for (int kk = 0; kk < NK; kk++) begin
            chk("reset_vld", vld_w[kk], 0);
            chk("reset_rdt", rdt_w[kk], 0);
            chk("reset_err", err_w[kk], 0);
            chk("reset_io", {re_w[kk], we_w[kk], dw_w[kk]}, 0);
        end
        rst  = 1'b0;
        seed = 1'b0;
        @(negedge clk);
        for (int kk = 0; kk < NK; kk++) chk("first_req_rdy", rdy_w[kk], 1);

        // Directed: ADR 0x20, WAIT 0
        txn(0, 1'b0, 6'h21, 8'h00, 0, 1'b0);
        txn(0, 1'b1, 6'h22, 8'h3C, 1, 1'b0);
        txn(0, 1'b0, 6'h23, 8'h00, 0, 1'b0);
        txn(0, 1'b0, 6'h1F, 8'h00, 2, 1'b0);
        txn(0, 1'b0, 6'h22, 8'h00, 0, 1'b1);

        // rsp_rdy with no response pending has no effect
        rsp_rdy[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rdy_vld", vld_w[0], 0);
            chk("idle_rdy_req_rdy", rdy_w[0], 1);
        end
        rsp_rdy[0] = 1'b0;

        // WAIT 3 with a slow consumer
        txn(1, 1'b0, 6'h20, 8'h00, 5, 1'b1);

        // Reset while the write sits in WAIT
        s0         = n_strb[1];
        req_vld[1] = 1'b1;
        req_we[1]  = 1'b1;
        req_adr[1] = 6'h20;
        req_wdt[1] = 8'h5A;
        @(negedge clk);
        req_vld[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_mem[1][0] = 8'h5A;
        chk("rst_req_rdy", rdy_w[1], 1);
        chk("rst_vld", vld_w[1], 0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_after_vld", vld_w[1], 0);
        end
        chk("rst_strobes", n_strb[1] - s0, 1);
        txn(1, 1'b0, 6'h20, 8'h00, 0, 1'b0);

        // ADR 0x3E: no wrap-around alias at 0x00
        txn(2, 1'b0, 6'h00, 8'h00, 0, 1'b0);
        txn(2, 1'b0, 6'h3F, 8'h00, 1, 1'b0);

        // Random back-to-back traffic against the model
        for (int t = 0; t < 60; t++) begin
            k = int'($urandom_range(0, NK - 1));
            if ($urandom_range(0, 7) == 0) a = 6'($urandom);
            else a = base_of(k) + 6'($urandom_range(0, 6)) - 6'd2;
            dly = int'($urandom_range(0, 3));
            txn(k, 1'($urandom), a, 8'($urandom), dly, 1'($urandom));
        end

        for (int kk = 0; kk < NK; kk++) chk("protocol", bad[kk], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
